vga_frame_reader: RTL and testbench
===================================

// Module: vga_frame_reader
// PURPOSE
//  Scan-out side of the 320x240 RGB332 frame-buffer RAM. It generates 640x480@60 VGA timing from a 25 MHz pixel clock.
//  It issues sequential read requests to the RAM read port, with every stored pixel doubled horizontally and vertically.
//  It converts returned bytes to 4-bit-per-colour DAC outputs, with sync and data-enable aligned to the pixel data.
//  It sits between the frame-buffer RAM and the board VGA connector; the capture/writer side signals frame completion.
// PARAMETERS
//  H_VISIBLE  640    visible pixels per line
//  H_FRONT    16     horizontal front porch, clocks
//  H_SYNC     96     hsync pulse width, clocks
//  H_BACK     48     horizontal back porch, clocks (H_TOTAL = 800)
//  V_VISIBLE  480    visible lines per frame
//  V_FRONT    10     vertical front porch, lines
//  V_SYNC     2      vsync pulse width, lines
//  V_BACK     33     vertical back porch, lines (V_TOTAL = 525)
//  FB_WIDTH   320    frame-buffer pixels per row; RAM_DEPTH = FB_WIDTH*FB_HEIGHT = 76800 (localparam)
//  FB_HEIGHT  240    frame-buffer rows
//  ADDR_WIDTH 17     RAM address width
// PORTS
//  clk_i          in   1   pixel clock, 25 MHz; sole clock
//  rst_i          in   1   asynchronous, active-high reset
//  enable_i       in   1   scan-out enable (level)
//  frame_ready_i  in   1   high for >=1 clk when the writer has completed a frame (write-done flag)
//  ram_data_i     in   8   RAM read data, RGB332 {R[7:5],G[4:2],B[1:0]}, valid 1 clk after request
//  ram_addr_o     out  17  RAM read address
//  ram_en_o       out  1   RAM enable
//  ram_re_o       out  1   RAM read enable (ram_en_o and ram_re_o always equal)
//  vga_r_o        out  4   red DAC
//  vga_g_o        out  4   green DAC
//  vga_b_o        out  4   blue DAC
//  hsync_o        out  1   horizontal sync, active low
//  vsync_o        out  1   vertical sync, active low
//  de_o           out  1   data enable: visible pixel on vga_*_o
//  read_done_o    out  1   1-clk pulse: last RAM address of the frame read for the final time
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0, FSM=IDLE, ready flag=0, hsync_o=vsync_o=1, all other outputs 0. Reset mid-frame aborts immediately.
//  - Counters run free in every state: h_cnt 0..799 wraps and increments v_cnt; v_cnt 0..524 wraps.
//  - Raw sync: hsync low for h_cnt 656..751; vsync low for v_cnt 490..491. Visible area: h<640 && v<480.
//  - Ready flag: set on any clk with frame_ready_i=1; cleared on entering SCAN.
//  - FSM IDLE -> ARMED: flag=1 && enable_i=1.
//  - FSM ARMED -> SCAN: at h=799, v=524, so scanning starts on a frame boundary.
//  - FSM SCAN -> IDLE: at h=799, v=524 if enable_i=0. A frame in progress always completes.
//  - FSM ARMED -> IDLE: enable_i=0.
//  - Request stage (combinational from counters): ram_en_o=ram_re_o=1 only in SCAN && visible.
//  - Request address: ram_addr_o = (v>>1)*FB_WIDTH + (h>>1), built from a row-base register advanced by FB_WIDTH after each odd visible line. No multiplier.
//  - Request address when not requesting: ram_addr_o=0.
//  - Latency: the RAM returns data at +1 clk. Outputs are registered at +2 clk relative to the counters.
//  - Alignment: hsync/vsync/de are delayed through 2 registers so all outputs align to the same counter value.
//  - Colour: vga_r_o={R,R[2]}, vga_g_o={G,G[2]}, vga_b_o={B,B}. Colour outputs are forced to 0 whenever delayed de=0 or the state is not SCAN.
//  - In IDLE/ARMED, sync keeps running and the screen is black.
//  - read_done_o: pulses once per frame, registered in the same cycle the request for h=639, v=479 (address 76799) is issued.
//  - Boundaries: address never exceeds RAM_DEPTH-1. No requests are made in blanking.
//  - frame_ready_i asserted during SCAN is absorbed (flag set; no effect until IDLE).
// TESTING
//  - Reset: assert rst_i asynchronously mid-line -> hsync_o=vsync_o=1, colour outputs 0, ram_en_o=0 on the same edge; counters 0.
//  - Timing: run 2 frames enable_i=0 -> hsync period 800 clk, low 96 clk; vsync period 420000 clk, low 1600 clk; colour 0 and ram_en_o never 1.
//  - Arming: frame_ready_i pulse at v=100, enable_i=1 -> first ram_en_o at the start of the next frame (h=0, v=0).
//  - Arming check: no requests before the next frame starts; ram_addr_o=0 at h=0, v=0.
//  - Addressing: in SCAN, h=0,1,2 at v=0 -> addr 0,0,1; v=1,h=0 -> 0; v=2,h=0 -> 320; h=639,v=479 -> 76799.
//  - Addressing check: read_done_o pulses exactly once at the address-76799 request.
//  - Data path: RAM model returns 8'hE3 at addr 0 -> vga_r_o=4'hF, vga_g_o=4'h0, vga_b_o=4'hF, 2 clk after the h=0,v=0 request.
//  - Data path check: de_o and sync are aligned with this pixel; value repeats for 2 pixels x 2 lines.
//  - Disable: drop enable_i at v=200 -> frame completes with read_done_o; next frame has no requests and black output.

Source files
------------

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scan-out side of a 320x240 RGB332 frame buffer.
// Generates 640x480@60 VGA timing, reads every stored pixel twice per line
// and on two consecutive lines, and drives 4-bit-per-colour DAC outputs with
// sync and data-enable aligned to the returned pixel data.
module vga_frame_reader #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  frame_ready_i,
    input  logic [7:0]            ram_data_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_en_o,
    output logic                  ram_re_o,
    output logic [3:0]            vga_r_o,
    output logic [3:0]            vga_g_o,
    output logic [3:0]            vga_b_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic                  read_done_o
);

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int RAM_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int H_W       = $clog2(H_TOTAL);
    localparam int V_W       = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
    localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
    localparam logic [H_W-1:0] H_VIS_LAST = H_W'(H_VISIBLE - 1);
    localparam logic [V_W-1:0] V_VIS_LAST = V_W'(V_VISIBLE - 1);
    localparam logic [H_W-1:0] HS_START   = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] HS_END     = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] VS_START   = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] VS_END     = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [H_W-1:0]          h_cnt;
    logic [V_W-1:0]          v_cnt;
    logic                    ready_flag;
    logic [ADDR_WIDTH-1:0]   row_base;
    logic                    h_last, frame_end, visible;
    logic                    hs_raw, vs_raw;
    logic                    req, last_req;
    logic                    de_d1, hs_d1, vs_d1;

    assign h_last    = (h_cnt == H_LAST);
    assign frame_end = h_last && (v_cnt == V_LAST);
    assign visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    assign hs_raw    = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw    = ~((v_cnt >= VS_START) && (v_cnt < VS_END));

    // Free-running raster counters; they keep sync alive in every state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Next-state logic: scanning only starts and stops on frame boundaries,
    // except that an armed reader falls back to idle as soon as enable drops.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps paths that do
        // not assign it from inferring a latch.
        state_next = state;
        case (state)
            ST_IDLE:  if (ready_flag && enable_i) state_next = ST_ARMED;
            ST_ARMED: begin
                if (!enable_i)      state_next = ST_IDLE;
                else if (frame_end) state_next = ST_SCAN;
            end
            ST_SCAN:  if (frame_end && !enable_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Write-done flag; a new frame_ready pulse wins over the clear so a
    // notification on the very cycle scanning begins is not lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                          ready_flag <= 1'b0;
        else if (frame_ready_i)                             ready_flag <= 1'b1;
        else if (state != ST_SCAN && state_next == ST_SCAN) ready_flag <= 1'b0;
    end

    // Row base: start address of the current frame-buffer row; each stored
    // row is shown on two lines, so it advances after every odd visible line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            row_base <= '0;
        else if (frame_end)
            row_base <= '0;
        else if (h_last && (v_cnt < V_VIS_END) && v_cnt[0])
            row_base <= row_base + ROW_STEP;
    end

    // Request stage: combinational from the counters, pixel doubled by h>>1.
    assign req        = (state == ST_SCAN) && visible;
    assign ram_en_o   = req;
    assign ram_re_o   = req;
    assign ram_addr_o = req ? row_base + ADDR_WIDTH'(h_cnt[H_W-1:1]) : '0;
    // Address LAST_ADDR is fetched four times; the bottom-right raster
    // position marks the final one.
    assign last_req   = req && (h_cnt == H_VIS_LAST) && (v_cnt == V_VIS_LAST)
                        && (ram_addr_o == LAST_ADDR);

    // Frame-done pulse, one clock after the final request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) read_done_o <= 1'b0;
        else       read_done_o <= last_req;
    end

    // First delay stage: timing signals wait while the RAM returns data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_d1 <= 1'b0;
            hs_d1 <= 1'b1;
            vs_d1 <= 1'b1;
        end else begin
            de_d1 <= visible;
            hs_d1 <= hs_raw;
            vs_d1 <= vs_raw;
        end
    end

    // Output stage: RGB332 expanded to 4 bits per colour, black outside SCAN
    // or outside the visible area.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_o    <= 1'b0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            vga_r_o <= 4'h0;
            vga_g_o <= 4'h0;
            vga_b_o <= 4'h0;
        end else begin
            de_o    <= de_d1;
            hsync_o <= hs_d1;
            vsync_o <= vs_d1;
            if (de_d1 && state == ST_SCAN) begin
                vga_r_o <= {ram_data_i[7:5], ram_data_i[7]};
                vga_g_o <= {ram_data_i[4:2], ram_data_i[4]};
                vga_b_o <= {ram_data_i[1:0], ram_data_i[1:0]};
            end else begin
                vga_r_o <= 4'h0;
                vga_g_o <= 4'h0;
                vga_b_o <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: reduced-geometry instance checked cycle by cycle
// against a raster-position reference model, plus a full-geometry instance
// whose horizontal sync timing is measured.
`timescale 1ns/1ps
module tb_vga_frame_reader;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
    localparam int FBW = 8, FBH = 6, DEPTH = FBW * FBH, FRAME = HT * VT;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          frame_ready = 1'b0;
    logic [7:0]    ram_data = 8'h00;
    logic [AW-1:0] ram_addr;
    logic          ram_en, ram_re, hsync, vsync, de, rd;
    logic [3:0]    vga_r, vga_g, vga_b;

    logic          f_enable = 1'b0;
    logic          f_frame_ready = 1'b0;
    logic [7:0]    f_ram_data = 8'h00;
    logic [16:0]   f_ram_addr;
    logic          f_ram_en, f_ram_re, f_hsync, f_vsync, f_de, f_rd;
    logic [3:0]    f_r, f_g, f_b;

    always #20 clk = ~clk;

    vga_frame_reader #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_WIDTH(AW)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_ready_i(frame_ready),
        .ram_data_i(ram_data), .ram_addr_o(ram_addr), .ram_en_o(ram_en),
        .ram_re_o(ram_re), .vga_r_o(vga_r), .vga_g_o(vga_g), .vga_b_o(vga_b),
        .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .read_done_o(rd)
    );

    vga_frame_reader u_full (
        .clk_i(clk), .rst_i(rst), .enable_i(f_enable), .frame_ready_i(f_frame_ready),
        .ram_data_i(f_ram_data), .ram_addr_o(f_ram_addr), .ram_en_o(f_ram_en),
        .ram_re_o(f_ram_re), .vga_r_o(f_r), .vga_g_o(f_g), .vga_b_o(f_b),
        .hsync_o(f_hsync), .vsync_o(f_vsync), .de_o(f_de), .read_done_o(f_rd)
    );

    // Frame-buffer RAM: data one clock after an enabled request.
    logic [7:0] mem [DEPTH];
    always @(posedge clk) if (ram_en) ram_data <= mem[int'(ram_addr) % DEPTH];

    // Full-geometry hsync measurement, in clocks.
    int f_cyc, f_fall, f_period, f_low;
    logic f_prev;
    always @(negedge clk) begin
        if (rst) begin
            f_cyc = 0; f_fall = -1; f_period = 0; f_low = 0; f_prev = 1'b1;
        end else begin
            f_cyc++;
            if (f_hsync !== f_prev) begin
                if (!f_hsync) begin
                    if (f_fall >= 0) f_period = f_cyc - f_fall;
                    f_fall = f_cyc;
                end else begin
                    f_low = f_cyc - f_fall;
                end
            end
            f_prev = f_hsync;
        end
    end

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_ARMED, M_SCAN} mode_e;
    typedef struct packed {
        logic          de, hs, vs, lit, last;
        logic [7:0]    data;
        logic [AW-1:0] addr;
    } pix_t;

    localparam pix_t RESET_PIX = '{de: 1'b0, hs: 1'b1, vs: 1'b1, lit: 1'b0,
                                   last: 1'b0, data: 8'h00, addr: '0};

    int    t;
    mode_e m_mode;
    bit    m_flag;
    pix_t  e0, e1, e2;   // raster position t, t-1, t-2
    int    checks = 0, errors = 0;
    int    rd_count = 0, req_count = 0, lit_count = 0;
    int    s_hfall, s_hper, s_hlow, s_vfall, s_vper, s_vlow;
    logic  s_prev_hs, s_prev_vs;

    function automatic pix_t make_pix(input int tt, input bit scanning);
        pix_t p;
        int h, v;
        bit vis;
        h = tt % HT;
        v = (tt / HT) % VT;
        vis    = (h < HV) && (v < VV);
        p      = RESET_PIX;
        p.de   = vis;
        p.hs   = !(h >= HV + HF && h < HV + HF + HS);
        p.vs   = !(v >= VV + VF && v < VV + VF + VS);
        p.lit  = scanning && vis;
        p.addr = p.lit ? AW'((v / 2) * FBW + h / 2) : '0;
        p.last = p.lit && (h == HV - 1) && (v == VV - 1);
        return p;
    endfunction

    function automatic logic [11:0] rgb_of(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    task automatic model_reset();
        t = 0; m_mode = M_OFF; m_flag = 1'b0;
        e1 = RESET_PIX; e2 = RESET_PIX; e0 = make_pix(0, 1'b0);
        s_hfall = -1; s_hper = 0; s_hlow = 0; s_prev_hs = 1'b1;
        s_vfall = -1; s_vper = 0; s_vlow = 0; s_prev_vs = 1'b1;
    endtask

    // One clock of the scan-out rules: arm on flag+enable, start/stop scanning
    // only at the end of a frame, abandon arming when enable drops.
    task automatic model_edge(input bit en, input bit fr);
        bit    at_end;
        mode_e nxt;
        at_end = ((t % HT) == HT - 1) && (((t / HT) % VT) == VT - 1);
        nxt = m_mode;
        if (m_mode == M_OFF && m_flag && en)        nxt = M_ARMED;
        else if (m_mode == M_ARMED && !en)          nxt = M_OFF;
        else if (m_mode == M_ARMED && at_end)       nxt = M_SCAN;
        else if (m_mode == M_SCAN && at_end && !en) nxt = M_OFF;
        if (fr) m_flag = 1'b1;
        else if (nxt == M_SCAN && m_mode != M_SCAN) m_flag = 1'b0;
        m_mode = nxt;
        t++;
        e2 = e1; e1 = e0;
        e0 = make_pix(t, m_mode == M_SCAN);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic track_sync();
        if (hsync !== s_prev_hs) begin
            if (!hsync) begin
                if (s_hfall >= 0) s_hper = t - s_hfall;
                s_hfall = t;
            end else s_hlow = t - s_hfall;
        end
        if (vsync !== s_prev_vs) begin
            if (!vsync) begin
                if (s_vfall >= 0) s_vper = t - s_vfall;
                s_vfall = t;
            end else s_vlow = t - s_vfall;
        end
        s_prev_hs = hsync; s_prev_vs = vsync;
    endtask

    // Advance one clock and compare every output with the model.
    task automatic step();
        bit en_s, fr_s;
        logic [34:0] act, exp;
        en_s = enable; fr_s = frame_ready;
        e0.data = e0.lit ? mem[int'(e0.addr) % DEPTH] : 8'h00;
        @(posedge clk);
        model_edge(en_s, fr_s);
        #1;
        act = {ram_en, ram_re, ram_addr, vga_r, vga_g, vga_b, hsync, vsync, de, rd};
        exp = {e0.lit, e0.lit, e0.addr, (e2.lit ? rgb_of(e2.data) : 12'h000),
               e2.hs, e2.vs, e2.de, e1.last};
        check($sformatf("cycle t=%0d h=%0d v=%0d", t, t % HT, (t / HT) % VT), 64'(act), 64'(exp));
        if (rd) rd_count++;
        if (ram_en) req_count++;
        if ({vga_r, vga_g, vga_b} != 12'h000) lit_count++;
        track_sync();
    endtask

    task automatic run_to(input int h, input int v, input int bound);
        int n;
        n = 0;
        while (!((t % HT) == h && ((t / HT) % VT) == v) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            checks++; errors++;
            $display("FAIL run_to h=%0d v=%0d: not reached in %0d clocks", h, v, bound);
        end
    endtask

    task automatic rearm();
        enable = 1'b1; frame_ready = 1'b1; step(); frame_ready = 1'b0;
        run_to(0, 0, FRAME); step(); run_to(0, 0, FRAME);
        check("scan active at frame start", ram_en, 1);
    endtask

    // Asynchronous reset between clock edges; outputs must react immediately.
    task automatic reset_mid(input string tag);
        #7 rst = 1'b1;
        #1;
        check({tag, " hsync"}, hsync, 1);
        check({tag, " vsync"}, vsync, 1);
        check({tag, " de"}, de, 0);
        check({tag, " rgb"}, {vga_r, vga_g, vga_b}, 0);
        check({tag, " ram_en"}, ram_en, 0);
        check({tag, " ram_addr"}, ram_addr, 0);
        #5 rst = 1'b0;
        model_reset();
    endtask

    typedef struct { int h; int v; logic [AW-1:0] addr; bit chk_rgb; logic [11:0] rgb; } addr_vec_t;
    typedef struct { logic [7:0] data; logic [11:0] rgb; } col_vec_t;
    addr_vec_t av [11];
    col_vec_t  cv [6];

    initial begin
        int t_pulse, exp_start, n;

        av[0]  = '{0, 0, 0, 1'b0, 12'h000};
        av[1]  = '{1, 0, 0, 1'b0, 12'h000};
        av[2]  = '{2, 0, 1, 1'b1, 12'hF0F};
        av[3]  = '{3, 0, 1, 1'b1, 12'hF0F};
        av[4]  = '{4, 0, 2, 1'b1, 12'h000};
        av[5]  = '{0, 1, 0, 1'b0, 12'h000};
        av[6]  = '{2, 1, 1, 1'b1, 12'hF0F};
        av[7]  = '{3, 1, 1, 1'b1, 12'hF0F};
        av[8]  = '{0, 2, 8, 1'b0, 12'h000};
        av[9]  = '{5, 3, 10, 1'b0, 12'h000};
        av[10] = '{15, 11, 47, 1'b0, 12'h000};
        cv[0] = '{8'hE3, 12'hF0F};
        cv[1] = '{8'h00, 12'h000};
        cv[2] = '{8'hFF, 12'hFFF};
        cv[3] = '{8'h1C, 12'h0F0};
        cv[4] = '{8'h49, 12'h445};
        cv[5] = '{8'hB6, 12'hBBA};
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mem[0] = 8'hE3;

        // Reset values.
        model_reset();
        repeat (3) @(posedge clk);
        #5;
        check("reset hsync", hsync, 1);
        check("reset vsync", vsync, 1);
        check("reset de", de, 0);
        check("reset rgb", {vga_r, vga_g, vga_b}, 0);
        check("reset ram_en", ram_en, 0);
        check("reset ram_addr", ram_addr, 0);
        check("reset read_done", rd, 0);
        check("reset full hsync", f_hsync, 1);
        #10 rst = 1'b0;

        // Two frames disabled: timing only, no requests, black screen.
        repeat (2 * FRAME) step();
        check("hsync period", s_hper, HT);
        check("hsync low", s_hlow, HS);
        check("vsync period", s_vper, FRAME);
        check("vsync low", s_vlow, VS * HT);
        check("requests while disabled", req_count, 0);
        check("colour while disabled", lit_count, 0);

        // Arming mid-frame: first request exactly at the next frame start.
        run_to(0, 5, FRAME);
        t_pulse = t;
        enable = 1'b1; frame_ready = 1'b1; step(); frame_ready = 1'b0;
        exp_start = (t_pulse / FRAME + 1) * FRAME;
        req_count = 0; n = 0;
        while (ram_en !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
        check("first request cycle", t, exp_start);
        check("first request addr", ram_addr, 0);
        check("requests before frame start", req_count, 1);

        // Address and pixel-doubling table for the first scanned frame.
        rd_count = 0;
        for (int i = 0; i < 11; i++) begin
            run_to(av[i].h, av[i].v, FRAME);
            check($sformatf("addr h=%0d v=%0d", av[i].h, av[i].v), {ram_en, ram_addr}, {1'b1, av[i].addr});
            if (av[i].chk_rgb) begin
                check($sformatf("rgb h=%0d v=%0d", av[i].h, av[i].v), {vga_r, vga_g, vga_b}, av[i].rgb);
                check($sformatf("de/sync h=%0d v=%0d", av[i].h, av[i].v), {de, hsync, vsync}, 3'b111);
            end
        end
        run_to(0, 0, FRAME);
        check("read_done pulses in frame", rd_count, 1);

        // Colour conversion table, one frame per vector.
        for (int i = 0; i < 6; i++) begin
            mem[0] = cv[i].data;
            run_to(2, 0, FRAME);
            check($sformatf("colour %02h", cv[i].data), {vga_r, vga_g, vga_b}, cv[i].rgb);
            run_to(0, 0, FRAME);
        end

        // Random RAM contents, random write-done pulses and enable changes.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        repeat (6 * FRAME) begin
            if ($urandom_range(0, 199) == 0) frame_ready = 1'b1;
            if ((t % FRAME) == 0) enable = ($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 399) == 0) enable = ~enable;
            step();
            frame_ready = 1'b0;
        end

        // Disable mid-frame: the frame completes, the next is black.
        rearm();
        rd_count = 0;
        run_to(0, VV / 2, FRAME);
        enable = 1'b0;
        run_to(0, 0, FRAME);
        check("read_done in final frame", rd_count, 1);
        req_count = 0; lit_count = 0;
        step(); run_to(0, 0, FRAME);
        check("requests after disable", req_count, 0);
        check("colour after disable", lit_count, 0);

        check("full hsync period", f_period, 800);
        check("full hsync low", f_low, 96);

        // Asynchronous resets mid-line: once while requesting, once in sync.
        rearm();
        run_to(5, 3, FRAME);
        check("request before reset", ram_en, 1);
        reset_mid("reset scan");
        enable = 1'b0;
        run_to(HV + HF + HS, VV + VF, FRAME);
        check("syncs low before reset", {hsync, vsync}, 2'b00);
        reset_mid("reset sync");
        repeat (FRAME) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(60000 * 40);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
